// File: rtl/aes_pkg.sv
// Shared AES byte tables and state permutation helpers.
// INV_SBOX is only elaborated when AES_SUBSHIFT_INV_EN is defined.
package aes_pkg;

  localparam int AES_BYTES = 16;

  // Byte k of the 128-bit state lives at [byte_msb(k) -: 8], column-major.
  function automatic int byte_msb(input int k);
    return 127 - 8 * k;
  endfunction

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_SUBSHIFT_INV_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

  // out(r,c) = in(r,(c+r) mod 4)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_msb(4 * c + r) -: 8] = s[byte_msb(4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  // out(r,c) = in(r,(c-r+4) mod 4)
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_msb(4 * c + r) -: 8] = s[byte_msb(4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup; inv selects the inverse table only when
// AES_SUBSHIFT_INV_EN is defined, otherwise the forward table is always used.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] din,
  output logic [7:0] dout
);

`ifdef AES_SUBSHIFT_INV_EN
  assign dout = inv ? INV_SBOX[din] : SBOX[din];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign dout = SBOX[din];
`endif

endmodule

// File: rtl/aes_sub_shift_stage.sv
// Iterative SubBytes + ShiftRows stage feeding MixColumns, LANES bytes per cycle.
// Optional AES_SUBSHIFT_INV_EN adds the inv port for InvSubBytes + InvShiftRows.
module aes_sub_shift_stage
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
`ifdef AES_SUBSHIFT_INV_EN
  input  logic         inv,
`endif
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         done,
  output logic         busy
);

  localparam int N  = AES_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SUB  = 1'b1;

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  st_q;
  logic [127:0]  st_sub;
  logic [127:0]  shifted;
  logic          sbox_inv;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

`ifdef AES_SUBSHIFT_INV_EN
  logic inv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_q <= 1'b0;
    end else if (state_q == S_IDLE && enable) begin
      inv_q <= inv;
    end
  end

  assign sbox_inv = inv_q;
  assign shifted  = inv_q ? inv_shift_rows(st_sub) : shift_rows(st_sub);
`else
  assign sbox_inv = 1'b0;
  assign shifted  = shift_rows(st_sub);
`endif

  assign busy = (state_q == S_SUB);

  // Group cnt_q selects which LANES bytes pass through the shared S-boxes.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i] = st_q[byte_msb(int'(cnt_q) * LANES + i) -: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .inv  (sbox_inv),
      .din  (lane_in[g]),
      .dout (lane_out[g])
    );
  end

  always_comb begin
    st_sub = st_q;
    for (int i = 0; i < LANES; i++) begin
      st_sub[byte_msb(int'(cnt_q) * LANES + i) -: 8] = lane_out[i];
    end
  end

  // Working state carries no reset; a partial block is dropped by the FSM.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      if (enable) begin
        st_q <= data_in;
      end
    end else begin
      st_q <= st_sub;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_SUB;
            cnt_q   <= '0;
          end
        end
        S_SUB: begin
          if (cnt_q == CNT_LAST) begin
            data_out <= shifted;
            done     <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift_stage.sv
// Randomised self-checking bench for aes_sub_shift_stage at LANES=4, 1 and 16.
// The S-box reference is derived from GF(2^8) inversion plus the affine map.
module tb_aes_sub_shift_stage;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         inv;
  logic         en4, en1, en16;
  logic [127:0] din4, din1, din16;
  logic [127:0] dout4, dout1, dout16;
  logic         done4, done1, done16;
  logic         busy4, busy1, busy16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  aes_sub_shift_stage #(.LANES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(en4),
`ifdef AES_SUBSHIFT_INV_EN
    .inv(inv),
`endif
    .data_in(din4), .data_out(dout4), .done(done4), .busy(busy4)
  );

  aes_sub_shift_stage #(.LANES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en1),
`ifdef AES_SUBSHIFT_INV_EN
    .inv(inv),
`endif
    .data_in(din1), .data_out(dout1), .done(done1), .busy(busy1)
  );

  aes_sub_shift_stage #(.LANES(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .enable(en16),
`ifdef AES_SUBSHIFT_INV_EN
    .inv(inv),
`endif
    .data_in(din16), .data_out(dout16), .done(done16), .busy(busy16)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic void build_tables();
    logic [7:0] x, y, iv, s;
    for (int a = 0; a < 256; a++) begin
      x  = 8'(a);
      iv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        y = 8'(b);
        if (x != 8'h00 && gmul(x, y) == 8'h01) iv = y;
      end
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = x;
    end
  endfunction

  // Reference: byte k sits at row k%4, column k/4; substitute then rotate rows.
  function automatic logic [127:0] model(input logic [127:0] x, input logic iv);
    logic [7:0]   s [16];
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) begin
      s[k] = iv ? inv_tab[x[127-8*k -: 8]] : fwd_tab[x[127-8*k -: 8]];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        y[127-8*(4*c+r) -: 8] = iv ? s[4*((c-r+4)%4)+r] : s[4*((c+r)%4)+r];
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 1) ? done1 : (sel == 16) ? done16 : done4;
  endfunction

  // Start one block on the chosen instance and wait (bounded) for done.
  task automatic blk(input int sel, input logic [127:0] d, input logic iv,
                     output logic [127:0] q, output int lat, output bit to);
    @(negedge clk);
    inv = iv;
    case (sel)
      1:       begin en1  = 1'b1; din1  = d; end
      16:      begin en16 = 1'b1; din16 = d; end
      default: begin en4  = 1'b1; din4  = d; end
    endcase
    @(posedge clk); #1;
    en1 = 1'b0; en4 = 1'b0; en16 = 1'b0;
    inv = ~iv;
    din1 = rnd128(); din4 = rnd128(); din16 = rnd128();
    lat = 0;
    to  = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (done_of(sel)) break;
      if (lat >= 40) begin to = 1'b1; break; end
    end
    q = (sel == 1) ? dout1 : (sel == 16) ? dout16 : dout4;
    inv = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    en4 = 1'b0; en1 = 1'b0; en16 = 1'b0; inv = 1'b0;
    din4 = '0; din1 = '0; din16 = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dout4, dout1, dout16} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h expected 0", dout4, dout1, dout16);
    end
    n_tests++;
    if ({done4, done1, done16} !== 3'b000) begin
      n_fail++; $display("FAIL reset_done: got %b%b%b expected 000", done4, done1, done16);
    end
    n_tests++;
    if ({busy4, busy1, busy16} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy: got %b%b%b expected 000", busy4, busy1, busy16);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fips();
    logic [127:0] q;
    int lat;
    bit to;
    blk(4, FIPS_IN, 1'b0, q, lat, to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL fips_timeout: got timeout expected done"); end
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL fips_latency: got %0d expected 4", lat); end
    n_tests++;
    if (q !== FIPS_OUT) begin n_fail++; $display("FAIL fips_data: got %h expected %h", q, FIPS_OUT); end
    n_tests++;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL fips_busy_at_done: got %b expected 0", busy4); end
    @(posedge clk); #1;
    n_tests++;
    if (done4 !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: got %b expected 0", done4); end
    n_tests++;
    if (dout4 !== FIPS_OUT) begin n_fail++; $display("FAIL fips_hold: got %h expected %h", dout4, FIPS_OUT); end
  endtask

  task automatic test_zero();
    logic [127:0] q;
    int lat;
    bit to;
    blk(4, '0, 1'b0, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || q !== {16{8'h63}}) begin
      n_fail++; $display("FAIL zero_data: got %h expected %h", q, {16{8'h63}});
    end
  endtask

  task automatic test_random();
    logic [127:0] d, q, e;
    int lat;
    bit to;
    for (int i = 0; i < 16; i++) begin
      d = rnd128();
      e = model(d, 1'b0);
      blk(4, d, 1'b0, q, lat, to);
      n_tests++;
      if (to !== 1'b0 || lat !== 4) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 4", i, lat);
      end
      n_tests++;
      if (q !== e) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, q, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [26];
    logic [127:0] e;
    logic exp_done;
    for (int i = 0; i < 26; i++) d[i] = rnd128();
    @(negedge clk);
    inv = 1'b0;
    en4 = 1'b1;
    din4 = d[0];
    for (int p = 0; p < 25; p++) begin
      @(posedge clk); #1;
      exp_done = (p >= 4) && (p % 5 == 4);
      n_tests++;
      if (done4 !== exp_done) begin
        n_fail++; $display("FAIL b2b_done[%0d]: got %b expected %b", p, done4, exp_done);
      end
      if (exp_done) begin
        e = model(d[p-4], 1'b0);
        n_tests++;
        if (dout4 !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", p, dout4, e); end
      end
      @(negedge clk);
      din4 = d[p+1];
    end
    en4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_while_busy();
    logic [127:0] a, q, e;
    int ndone, lat;
    a = rnd128();
    e = model(a, 1'b0);
    @(negedge clk);
    inv = 1'b0;
    en4 = 1'b1;
    din4 = a;
    @(posedge clk); #1;
    ndone = 0; lat = 0; q = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en4 = (c <= 3);
      din4 = rnd128();
      @(posedge clk); #1;
      if (done4) begin ndone++; lat = c; q = dout4; end
      if (c <= 3) begin
        n_tests++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL ign_busy[%0d]: got %b expected 1", c, busy4); end
      end
    end
    en4 = 1'b0;
    n_tests++;
    if (ndone !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", ndone); end
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL ign_latency: got %0d expected 4", lat); end
    n_tests++;
    if (q !== e) begin n_fail++; $display("FAIL ign_data: got %h expected %h", q, e); end
    n_tests++;
    if (dout4 !== e) begin n_fail++; $display("FAIL ign_hold: got %h expected %h", dout4, e); end
  endtask

  task automatic test_reset_mid_block();
    logic [127:0] q;
    int lat, ndone;
    bit to;
    @(negedge clk);
    inv = 1'b0;
    en4 = 1'b1;
    din4 = rnd128();
    @(posedge clk); #1;
    en4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (dout4 !== '0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", dout4); end
    n_tests++;
    if (done4 !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done4); end
    n_tests++;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy4); end
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done4 || busy4) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin n_fail++; $display("FAIL midrst_discard: got %0d active cycles expected 0", ndone); end
    blk(4, FIPS_IN, 1'b0, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || lat !== 4 || q !== FIPS_OUT) begin
      n_fail++; $display("FAIL midrst_next: got %h lat %0d expected %h lat 4", q, lat, FIPS_OUT);
    end
  endtask

  task automatic test_lanes();
    logic [127:0] d, q, e;
    int lat;
    bit to;
    blk(1, FIPS_IN, 1'b0, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || lat !== 16) begin n_fail++; $display("FAIL lanes1_latency: got %0d expected 16", lat); end
    n_tests++;
    if (q !== FIPS_OUT) begin n_fail++; $display("FAIL lanes1_data: got %h expected %h", q, FIPS_OUT); end
    blk(16, FIPS_IN, 1'b0, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL lanes16_latency: got %0d expected 1", lat); end
    n_tests++;
    if (q !== FIPS_OUT) begin n_fail++; $display("FAIL lanes16_data: got %h expected %h", q, FIPS_OUT); end
    for (int i = 0; i < 4; i++) begin
      d = rnd128();
      e = model(d, 1'b0);
      blk(1, d, 1'b0, q, lat, to);
      n_tests++;
      if (to !== 1'b0 || q !== e) begin n_fail++; $display("FAIL lanes1_rand[%0d]: got %h expected %h", i, q, e); end
      blk(16, d, 1'b0, q, lat, to);
      n_tests++;
      if (to !== 1'b0 || q !== e) begin n_fail++; $display("FAIL lanes16_rand[%0d]: got %h expected %h", i, q, e); end
    end
  endtask

`ifdef AES_SUBSHIFT_INV_EN
  task automatic test_inverse();
    logic [127:0] d, q, e, r;
    int lat;
    bit to;
    blk(4, FIPS_OUT, 1'b1, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || q !== FIPS_IN) begin n_fail++; $display("FAIL inv_fips: got %h expected %h", q, FIPS_IN); end
    for (int i = 0; i < 6; i++) begin
      d = rnd128();
      e = model(d, 1'b1);
      blk(4, d, 1'b1, q, lat, to);
      n_tests++;
      if (to !== 1'b0 || q !== e) begin n_fail++; $display("FAIL inv_rand[%0d]: got %h expected %h", i, q, e); end
      blk(4, q, 1'b0, r, lat, to);
      n_tests++;
      if (to !== 1'b0 || r !== d) begin n_fail++; $display("FAIL inv_roundtrip[%0d]: got %h expected %h", i, r, d); end
    end
    d = rnd128();
    e = model(d, 1'b1);
    blk(1, d, 1'b1, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || q !== e) begin n_fail++; $display("FAIL inv_lanes1: got %h expected %h", q, e); end
    blk(16, d, 1'b1, q, lat, to);
    n_tests++;
    if (to !== 1'b0 || q !== e) begin n_fail++; $display("FAIL inv_lanes16: got %h expected %h", q, e); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_zero();
    test_random();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_block();
    test_lanes();
`ifdef AES_SUBSHIFT_INV_EN
    test_inverse();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
